// File: rtl/pipe_cp0_intc_if.sv
// CPU <-> CP0 interrupt controller signal bundle.
// master: pipeline side (drives requests, reads results); slave: controller.
interface pipe_cp0_intc_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               int_ok;
  logic [31:0]        int_pc;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic [31:0]        exc_pc;
  logic               eret;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic               exc_take;
  logic [31:0]        exc_vector;
  logic               inta;
  logic [31:0]        epc;

  modport master (
    output irq, int_ok, int_pc, exc_valid, exc_code, exc_pc,
           eret, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_take, exc_vector, inta, epc
  );

  modport slave (
    input  irq, int_ok, int_pc, exc_valid, exc_code, exc_pc,
           eret, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_take, exc_vector, inta, epc
  );
endinterface

// File: rtl/pipe_cp0_intc.sv
// CP0 exception/interrupt controller: irq synchronisation and masking,
// exception/interrupt arbitration, STATUS/CAUSE/EPC with a nestable IE stack,
// one-cycle redirect strobe to IF, eret and mfc0/mtc0 support.
module pipe_cp0_intc #(
  parameter int          NUM_IRQ    = 4,
  parameter int          NEST_DEPTH = 2,
  parameter logic [31:0] EXC_BASE   = 32'h0000_0008,
  parameter bit          VECTORED   = 1'b0
) (
  input  logic            clock,
  input  logic            resetn,
  pipe_cp0_intc_if.slave  cpu
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic {RUN, TAKEN} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   sync1_q, ip_q;
  logic [NUM_IRQ-1:0]   im_q, im_d;
  logic                 ie_q, ie_d;
  logic [NEST_DEPTH-1:0] stack_q, stack_d;
  logic [2:0]           depth_q, depth_d;
  logic                 novf_q, novf_d;
  logic [4:0]           code_q, code_d;
  logic [31:0]          epc_q, epc_d;
  logic                 take_q, take_d;
  logic                 inta_q, inta_d;
  logic [31:0]          vec_q, vec_d;

  logic [NUM_IRQ-1:0]   pending;
  logic                 int_req;
  logic [2:0]           int_idx;
  logic                 found;
  logic [31:0]          status_rd, cause_rd;

  // Two-flop synchroniser on the asynchronous irq lines; IP is the second flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      ip_q    <= '0;
    end else begin
      sync1_q <= cpu.irq;
      ip_q    <= sync1_q;
    end
  end

  // Masked pending set and lowest-index winner.
  always_comb begin
    pending = ip_q & im_q;
    int_req = ie_q & (|pending) & cpu.int_ok;
    int_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && !found) begin
        int_idx = 3'(i);
        found   = 1'b1;
      end
    end
  end

  // Next-state: mtc0 writes first, then take/eret overwrite hardware-owned fields.
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    stack_d = stack_q;
    depth_d = depth_q;
    novf_d  = novf_q;
    code_d  = code_q;
    epc_d   = epc_q;
    take_d  = 1'b0;
    inta_d  = 1'b0;
    vec_d   = vec_q;

    if (cpu.cp0_we) begin
      case (cpu.cp0_addr)
        ADDR_STATUS: begin
          ie_d = cpu.cp0_wdata[0];
          im_d = cpu.cp0_wdata[8 +: NUM_IRQ];
          if (cpu.cp0_wdata[31]) novf_d = 1'b0;
        end
        ADDR_CAUSE: code_d = cpu.cp0_wdata[6:2];
        ADDR_EPC:   epc_d  = cpu.cp0_wdata;
        default: ;
      endcase
    end

    case (state_q)
      RUN: begin
        if (cpu.exc_valid || int_req) begin
          state_d = TAKEN;
          take_d  = 1'b1;
          inta_d  = !cpu.exc_valid;
          epc_d   = cpu.exc_valid ? cpu.exc_pc : cpu.int_pc;
          code_d  = cpu.exc_valid ? cpu.exc_code : 5'd0;
          if (VECTORED && !cpu.exc_valid)
            vec_d = EXC_BASE + ((32'(int_idx) + 32'd1) << 5);
          else
            vec_d = EXC_BASE;
          // Push current IE; at full depth the oldest entry falls off the top.
          stack_d = (stack_q << 1) | NEST_DEPTH'(ie_q);
          ie_d    = 1'b0;
          if (depth_q == 3'(NEST_DEPTH)) novf_d = 1'b1;
          else                            depth_d = depth_q + 3'd1;
        end else if (cpu.eret) begin
          ie_d    = (depth_q == 3'd0) ? 1'b0 : stack_q[0];
          stack_d = stack_q >> 1;
          if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
        end
      end
      TAKEN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Architectural registers and registered redirect outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      im_q    <= '0;
      ie_q    <= 1'b0;
      stack_q <= '0;
      depth_q <= '0;
      novf_q  <= 1'b0;
      code_q  <= '0;
      epc_q   <= '0;
      take_q  <= 1'b0;
      inta_q  <= 1'b0;
      vec_q   <= EXC_BASE;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      novf_q  <= novf_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      take_q  <= take_d;
      inta_q  <= inta_d;
      vec_q   <= vec_d;
    end
  end

  // mfc0 read mux.
  always_comb begin
    status_rd                   = '0;
    status_rd[0]                = ie_q;
    status_rd[NEST_DEPTH:1]     = stack_q;
    status_rd[8 +: NUM_IRQ]     = im_q;
    status_rd[31]               = novf_q;
    cause_rd                    = '0;
    cause_rd[6:2]               = code_q;
    cause_rd[8 +: NUM_IRQ]      = ip_q;
    case (cpu.cp0_addr)
      ADDR_STATUS: cpu.cp0_rdata = status_rd;
      ADDR_CAUSE:  cpu.cp0_rdata = cause_rd;
      ADDR_EPC:    cpu.cp0_rdata = epc_q;
      default:     cpu.cp0_rdata = '0;
    endcase
  end

  assign cpu.exc_take   = take_q;
  assign cpu.inta       = inta_q;
  assign cpu.exc_vector = vec_q;
  assign cpu.epc        = epc_q;

endmodule

// File: tb/tb_pipe_cp0_intc.sv
// Self-checking bench for pipe_cp0_intc: directed scenarios plus randomized
// traffic, all compared against a queue-based behavioural model.
module tb_pipe_cp0_intc;
  localparam int          NI   = 4;
  localparam int          ND   = 2;
  localparam logic [31:0] BASE = 32'h0000_0008;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  pipe_cp0_intc_if #(.NUM_IRQ(NI)) cpu ();

  pipe_cp0_intc #(
    .NUM_IRQ(NI), .NEST_DEPTH(ND), .EXC_BASE(BASE), .VECTORED(1'b1)
  ) dut (
    .clock(clock), .resetn(resetn), .cpu(cpu)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Behavioural model: saved-IE stack is a queue (front = most recent),
  // irq history is a two-entry queue (front = currently visible IP).
  bit              m_ie, m_novf, m_take, m_inta;
  logic [NI-1:0]   m_im;
  logic [4:0]      m_code;
  logic [31:0]     m_epc, m_vec;
  bit              m_stk[$];
  logic [NI-1:0]   m_hist[$];

  task automatic model_reset();
    m_ie = 0; m_novf = 0; m_take = 0; m_inta = 0;
    m_im = '0; m_code = '0; m_epc = '0; m_vec = BASE;
    m_stk.delete();
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'd12: begin
        r[0] = m_ie;
        foreach (m_stk[i]) r[1+i] = m_stk[i];
        r[8 +: NI] = m_im;
        r[31] = m_novf;
      end
      5'd13: begin
        r[6:2] = m_code;
        r[8 +: NI] = m_hist[0];
      end
      5'd14: r = m_epc;
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [NI-1:0] pend;
    logic [31:0]   w;
    int            idx;
    bit            run, intr, old_ie;
    w      = cpu.cp0_wdata;
    run    = !m_take;
    old_ie = m_ie;
    pend   = m_hist[0] & m_im;
    idx    = -1;
    for (int i = NI - 1; i >= 0; i--) if (pend[i]) idx = i;
    intr = old_ie && (idx >= 0) && cpu.int_ok;
    if (cpu.cp0_we) begin
      if (cpu.cp0_addr == 5'd12) begin
        m_ie = w[0];
        m_im = w[8 +: NI];
        if (w[31]) m_novf = 0;
      end else if (cpu.cp0_addr == 5'd13) m_code = w[6:2];
      else if (cpu.cp0_addr == 5'd14) m_epc = w;
    end
    m_take = 0;
    m_inta = 0;
    if (run && (cpu.exc_valid || intr)) begin
      m_take = 1;
      m_inta = !cpu.exc_valid;
      m_epc  = cpu.exc_valid ? cpu.exc_pc : cpu.int_pc;
      m_code = cpu.exc_valid ? cpu.exc_code : 5'd0;
      m_vec  = cpu.exc_valid ? BASE : BASE + 32 * (idx + 1);
      m_stk.push_front(old_ie);
      if (m_stk.size() > ND) begin
        void'(m_stk.pop_back());
        m_novf = 1;
      end
      m_ie = 0;
    end else if (run && cpu.eret) begin
      if (m_stk.size() == 0) m_ie = 0;
      else                   m_ie = m_stk.pop_front();
    end
    void'(m_hist.pop_front());
    m_hist.push_back(cpu.irq);
  endtask

  // One clock: inputs already driven; returns at the following negedge.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("exc_take", 32'(cpu.exc_take), 32'(m_take));
    check("inta", 32'(cpu.inta), 32'(m_inta));
    if (m_take) check("exc_vector", cpu.exc_vector, m_vec);
    check("epc", cpu.epc, m_epc);
    check("cp0_rdata", cpu.cp0_rdata, m_read(cpu.cp0_addr));
    @(negedge clock);
  endtask

  task automatic idle();
    cpu.exc_valid = 0; cpu.eret = 0; cpu.cp0_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cpu.cp0_we = 1; cpu.cp0_addr = a; cpu.cp0_wdata = d;
    cycle();
    cpu.cp0_we = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    model_reset();
    idle();
    cpu.irq = '0; cpu.int_ok = 0; cpu.int_pc = '0;
    cpu.exc_code = 5'd1; cpu.exc_pc = '0; cpu.cp0_addr = 5'd12; cpu.cp0_wdata = '0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_take", 32'(cpu.exc_take), 0);
    check("rst_inta", 32'(cpu.inta), 0);
    check("rst_epc", cpu.epc, 0);
    check("rst_status", cpu.cp0_rdata, 0);
    check("rst_vector", cpu.exc_vector, BASE);
    @(negedge clock);

    // Interrupt latency and per-IRQ vector.
    mtc0(5'd12, 32'h0000_0401);
    cpu.cp0_addr = 5'd12; cpu.int_ok = 1; cpu.int_pc = 32'h40; cpu.irq = 4'b0100;
    cycle(); cycle();
    check("lat_early", 32'(cpu.exc_take), 0);
    cycle();
    check("lat_take", 32'(cpu.exc_take), 1);
    check("lat_inta", 32'(cpu.inta), 1);
    check("lat_vec", cpu.exc_vector, 32'h68);
    check("lat_epc", cpu.epc, 32'h40);
    check("lat_status", cpu.cp0_rdata, 32'h0000_0402);

    // Lowest index wins; exception beats interrupt.
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    cpu.int_ok = 1; cpu.int_pc = 32'h44; cpu.irq = 4'b1010;
    cycle(); cycle(); cycle();
    check("prio_vec", cpu.exc_vector, 32'h48);
    check("prio_inta", 32'(cpu.inta), 1);
    cycle();
    cpu.eret = 1; cycle(); cpu.eret = 0;
    cpu.exc_valid = 1; cpu.exc_code = 5'd12; cpu.exc_pc = 32'h100; cpu.cp0_addr = 5'd13;
    cycle();
    idle();
    check("exc_take", 32'(cpu.exc_take), 1);
    check("exc_vec", cpu.exc_vector, 32'h08);
    check("exc_inta", 32'(cpu.inta), 0);
    check("exc_epc", cpu.epc, 32'h100);
    check("exc_cause", cpu.cp0_rdata, 32'h0000_0A30);

    // Nesting overflow and eret unwinding.
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    for (int n = 0; n < 3; n++) begin
      cpu.exc_valid = 1; cpu.exc_code = 5'd8; cpu.exc_pc = 32'h200 + 32'(4 * n);
      cycle();
      cpu.exc_valid = 0;
      mtc0(5'd12, 32'h0000_0F01);
    end
    cpu.cp0_addr = 5'd12;
    #1;
    check("nest_status", cpu.cp0_rdata, 32'h8000_0F07);
    cpu.eret = 1;
    cycle(); check("eret1_ie", 32'(cpu.cp0_rdata[0]), 1);
    cycle(); check("eret2_ie", 32'(cpu.cp0_rdata[0]), 1);
    cycle(); check("eret3_ie", 32'(cpu.cp0_rdata[0]), 0);
    idle();

    // Take beats eret; exceptions ignored in TAKEN.
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    cpu.exc_valid = 1; cpu.eret = 1; cpu.exc_code = 5'd4; cpu.exc_pc = 32'h30;
    cycle();
    check("te_take", 32'(cpu.exc_take), 1);
    check("te_status", cpu.cp0_rdata, 32'h0000_0F02);
    cpu.eret = 0; cpu.exc_pc = 32'h34;
    cycle();
    idle();
    check("taken_ign", 32'(cpu.exc_take), 0);
    check("taken_epc", cpu.epc, 32'h30);

    // mtc0 alongside a take.
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    cpu.int_ok = 1; cpu.int_pc = 32'h80; cpu.irq = 4'b0001;
    cycle(); cycle();
    mtc0(5'd14, 32'h200);
    check("wr_take", 32'(cpu.exc_take), 1);
    check("wr_epc", cpu.epc, 32'h80);
    cpu.cp0_addr = 5'd12;
    cycle();
    cpu.eret = 1; cycle(); cpu.eret = 0;
    mtc0(5'd12, 32'h0000_0301);
    check("wr_im_take", 32'(cpu.exc_take), 1);
    check("wr_im_status", cpu.cp0_rdata, 32'h0000_0302);

    // Reset during TAKEN.
    do_reset();
    mtc0(5'd12, 32'h0000_0F01);
    cpu.int_ok = 1; cpu.int_pc = 32'h90; cpu.irq = 4'b0001;
    cycle(); cycle(); cycle();
    check("pre_rst_take", 32'(cpu.exc_take), 1);
    resetn = 0;
    model_reset();
    #1;
    check("arst_take", 32'(cpu.exc_take), 0);
    check("arst_inta", 32'(cpu.inta), 0);
    check("arst_epc", cpu.epc, 0);
    check("arst_status", cpu.cp0_rdata, 0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cpu.irq = NI'($urandom);
      cpu.int_ok    = ($urandom_range(0, 9) < 8);
      cpu.int_pc    = $urandom & 32'hFFFF_FFFC;
      cpu.exc_valid = ($urandom_range(0, 9) == 0);
      cpu.exc_code  = 5'($urandom_range(1, 31));
      cpu.exc_pc    = $urandom & 32'hFFFF_FFFC;
      cpu.eret      = ($urandom_range(0, 7) == 0);
      cpu.cp0_we    = ($urandom_range(0, 5) == 0);
      cpu.cp0_addr  = 5'($urandom_range(10, 15));
      cpu.cp0_wdata = $urandom;
      if ($urandom_range(0, 1) == 1) cpu.cp0_wdata[0] = 1'b1;
      cycle();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
